piano_tone_gen: RTL and testbench

Parametrised multi-key square-wave tone generator for the board's audio pin. It replaces the fixed two-button tone block. Each key input gets a synchroniser and a debouncer. The lowest-indexed held key is selected, and an octave shift scales its pitch. The square wave is glitch-free: period changes take effect only on half-period boundaries. The output drives a single audio GPIO directly, or feeds a later PWM/mixer stage.

---
 rtl/piano_tone_gen.sv | 179 +++++++++++++++++
 tb/tb_piano_tone_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piano_tone_gen.sv
// -----------------------------------------------------------------------------
// piano_tone_gen
//
// Multi-key square-wave tone generator. Every key goes through a 2-FF
// synchroniser and its own debouncer. The lowest-indexed debounced key is
// selected, and its half-period is scaled down by the octave shift. The
// half-period counter only reloads at zero, so note and octave changes never
// cut a half-period short. Releasing all keys lets the current half-period
// finish and then parks the output low.
//
// Parameters
//   CLK_HZ          clock frequency in Hz, used to build the half-period table
//   N_KEYS          number of key inputs (1..8)
//   DEBOUNCE_CYCLES consecutive differing cycles needed to flip a key (>= 1)
//   CNT_W           width of the half-period counter
//
// Ports
//   clk_25mhz  in   system clock
//   reset      in   asynchronous active-high reset
//   btn        in   raw key levels, active-high, asynchronous [N_KEYS]
//   octave     in   octave shift 0..3, each step doubles the pitch [2]
//   audio      out  square-wave tone
//   active     out  high while any debounced key is held
//   note       out  index of the selected key, 0 when nothing is held [3]
// -----------------------------------------------------------------------------
module piano_tone_gen #(
    parameter int CLK_HZ          = 25000000,
    parameter int N_KEYS          = 7,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 26
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic [N_KEYS-1:0] btn,
    input  logic [1:0]        octave,
    output logic              audio,
    output logic              active,
    output logic [2:0]        note
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    function automatic int base_freq(input int idx);
        case (idx)
            0:       return 440;
            1:       return 494;
            2:       return 523;
            3:       return 587;
            4:       return 659;
            5:       return 698;
            6:       return 784;
            default: return 880;
        endcase
    endfunction

    function automatic int half_of(input int idx);
        return CLK_HZ / (2 * base_freq(idx));
    endfunction

    // Elaboration-time parameter checks.
    generate
        if (N_KEYS < 1 || N_KEYS > 8) begin : g_bad_keys
            $error("piano_tone_gen: N_KEYS must be in 1..8");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
            $error("piano_tone_gen: DEBOUNCE_CYCLES must be >= 1");
        end
        if ((longint'(half_of(0)) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt
            $error("piano_tone_gen: CNT_W too narrow for the lowest key");
        end
    endgenerate

    // Half-period table, one bit wider than the counter so HALF itself never
    // wraps even when only HALF-1 fits. All 8 entries exist so any 3-bit
    // index is in range.
    logic [CNT_W:0] half_tbl [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_half
            assign half_tbl[gi] = (CNT_W+1)'(half_of(gi));
        end
    endgenerate

    // ---------------- synchroniser + debouncer ----------------
    logic [N_KEYS-1:0] sync1_reg;
    logic [N_KEYS-1:0] btn_s_reg;
    logic [N_KEYS-1:0] btn_db_reg;
    logic [N_KEYS-1:0] btn_db_next;
    logic [DB_W-1:0]   db_cnt_reg  [N_KEYS];
    logic [DB_W-1:0]   db_cnt_next [N_KEYS];

    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic diff;
            logic done;
            assign diff = btn_s_reg[gi] ^ btn_db_reg[gi];
            assign done = (db_cnt_reg[gi] == DB_LAST);
            // Flip on the edge where the run of differing cycles completes.
            assign btn_db_next[gi] = (diff && done) ? btn_s_reg[gi] : btn_db_reg[gi];
            assign db_cnt_next[gi] = (!diff || done) ? '0 : db_cnt_reg[gi] + 1'b1;
        end
    endgenerate

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            sync1_reg  <= '0;
            btn_s_reg  <= '0;
            btn_db_reg <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt_reg[i] <= '0;
            end
        end else begin
            sync1_reg  <= btn;
            btn_s_reg  <= sync1_reg;
            btn_db_reg <= btn_db_next;
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt_reg[i] <= db_cnt_next[i];
            end
        end
    end

    // ---------------- key selection ----------------
    logic       sel_valid;
    logic [2:0] sel_idx;

    always_comb begin
        sel_idx = 3'd0;
        // Descending scan: the last hit is the lowest set bit.
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (btn_db_reg[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    assign sel_valid = |btn_db_reg;
    assign active    = sel_valid;
    assign note      = sel_valid ? sel_idx : 3'd0;

    // ---------------- half-period and tone counter ----------------
    logic [CNT_W:0]   half_shift;
    logic [CNT_W:0]   half_clamped;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             audio_reg;
    logic             audio_next;

    assign half_shift   = half_tbl[sel_idx] >> octave;
    assign half_clamped = (half_shift == '0) ? (CNT_W+1)'(1) : half_shift;

    always_comb begin
        cnt_next   = cnt_reg;
        audio_next = audio_reg;
        if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end else if (sel_valid) begin
            // Reload point: the only place a new pitch is picked up.
            audio_next = ~audio_reg;
            cnt_next   = CNT_W'(half_clamped - 1'b1);
        end else begin
            audio_next = 1'b0;
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            audio_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            audio_reg <= audio_next;
        end
    end

    assign audio = audio_reg;

endmodule

// File: tb/tb_piano_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_piano_tone_gen
//
// Self-checking bench for piano_tone_gen with CLK_HZ=8800, DEBOUNCE_CYCLES=4,
// N_KEYS=7 (HALF[0]=10, HALF[1]=8). Directed scenarios check fixed cycle
// offsets derived from the key-press latency rules; a randomised run compares
// every cycle against a behavioural model built from the same rules.
// -----------------------------------------------------------------------------
module tb_piano_tone_gen;

    localparam int CLK_HZ = 8800;
    localparam int NK     = 7;
    localparam int DB     = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] btn = '0;
    logic [1:0]    octave = 2'd0;
    logic          audio;
    logic          active;
    logic [2:0]    note;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piano_tone_gen #(
        .CLK_HZ(CLK_HZ), .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .CNT_W(26)
    ) dut (
        .clk_25mhz(clk), .reset(rst), .btn(btn), .octave(octave),
        .audio(audio), .active(active), .note(note)
    );

    // ---------------- behavioural model ----------------
    int            freq [8] = '{440, 494, 523, 587, 659, 698, 784, 880};
    bit [NK-1:0]   m_s1, m_s2, m_db;
    int            m_run [NK];      // consecutive edges btn_s has differed from db
    int            m_remain;        // edges left before the next reload point
    bit            m_aud;

    function automatic int m_half(input int idx, input int oct);
        int h;
        h = (CLK_HZ / (2 * freq[idx])) >> oct;
        if (h < 1) h = 1;
        return h;
    endfunction

    function automatic int lowest(input bit [NK-1:0] v);
        for (int i = 0; i < NK; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit exp_active();
        return m_db != '0;
    endfunction

    function automatic int exp_note();
        return (m_db != '0) ? lowest(m_db) : 0;
    endfunction

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_remain = 0; m_aud = 1'b0;
        for (int i = 0; i < NK; i++) m_run[i] = 0;
    endtask

    // Advance one clock edge (model follows the same edge), then settle 1 time unit.
    task automatic tick();
        bit [NK-1:0] old_db, old_s2;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            old_db = m_db;
            old_s2 = m_s2;
            m_s2 = m_s1;
            m_s1 = btn;
            for (int i = 0; i < NK; i++) begin
                if (old_s2[i] == old_db[i]) m_run[i] = 0;
                else if (m_run[i] + 1 >= DB) begin m_db[i] = old_s2[i]; m_run[i] = 0; end
                else m_run[i] = m_run[i] + 1;
            end
            if (m_remain > 0) m_remain = m_remain - 1;
            else if (old_db != '0) begin
                m_aud = ~m_aud;
                m_remain = m_half(lowest(old_db), int'(octave)) - 1;
            end else m_aud = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        btn = '0; octave = 2'd0; rst = 1'b1; model_clear();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        btn = '0; rst = 1'b1; model_clear();
        repeat (3) tick();
        checks++; if (audio !== 1'b0) begin failures++; $display("FAIL reset_audio got=%b exp=0", audio); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
        checks++; if (note !== 3'd0) begin failures++; $display("FAIL reset_note got=%0d exp=0", note); end
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            checks++;
            if (audio !== 1'b0) begin failures++; $display("FAIL idle_audio cyc=%0d got=%b exp=0", k, audio); end
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_debounce();
        bit ea, eau;
        do_reset();
        btn = 7'b0000001;
        for (int k = 0; k <= 40; k++) begin   // edge E+k
            tick();
            ea  = (k >= 5);
            eau = (k >= 6) && (((k - 6) / 10) % 2 == 0);
            checks++; if (active !== ea) begin failures++; $display("FAIL deb_active E+%0d got=%b exp=%b", k, active, ea); end
            checks++; if (audio !== eau) begin failures++; $display("FAIL deb_audio E+%0d got=%b exp=%b", k, audio, eau); end
        end
        do_reset();
        btn = 7'b0000001;
        repeat (3) tick();
        btn = '0;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++; if (active !== 1'b0) begin failures++; $display("FAIL bounce_active cyc=%0d got=%b exp=0", k, active); end
            checks++; if (audio !== 1'b0) begin failures++; $display("FAIL bounce_audio cyc=%0d got=%b exp=0", k, audio); end
        end
        $display("test_debounce done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_priority();
        int cyc = 0, t_prev = -1, t1 = -1, t2 = -1, t_change = -1;
        bit prev;
        do_reset();
        btn = 7'b0000011;
        for (int k = 0; k < 60; k++) begin
            prev = audio; tick(); cyc++;
            if (audio != prev) t_prev = cyc;
            checks++; if (active && note !== 3'd0) begin failures++; $display("FAIL prio_note0 cyc=%0d got=%0d exp=0", cyc, note); end
            checks++; if (audio !== m_aud) begin failures++; $display("FAIL prio_audio cyc=%0d got=%b exp=%b", cyc, audio, m_aud); end
        end
        btn = 7'b0000010;
        for (int k = 0; k < 60; k++) begin
            prev = audio; tick(); cyc++;
            if (t_change < 0 && note == 3'd1) t_change = cyc;
            if (audio != prev) begin
                if (t_change < 0) t_prev = cyc;
                else if (t1 < 0) t1 = cyc;
                else if (t2 < 0) t2 = cyc;
            end
            checks++; if (note !== 3'(exp_note())) begin failures++; $display("FAIL prio_note cyc=%0d got=%0d exp=%0d", cyc, note, exp_note()); end
            checks++; if (audio !== m_aud) begin failures++; $display("FAIL prio_audio2 cyc=%0d got=%b exp=%b", cyc, audio, m_aud); end
        end
        checks++; if (t1 - t_prev != 10) begin failures++; $display("FAIL prio_old_half got=%0d exp=10", t1 - t_prev); end
        checks++; if (t2 - t1 != 8) begin failures++; $display("FAIL prio_new_half got=%0d exp=8", t2 - t1); end
        $display("test_priority done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_octave();
        int toggles;
        bit prev;
        do_reset();
        octave = 2'd2; btn = 7'b0000001;
        repeat (8) tick();
        toggles = 0;
        for (int k = 0; k < 20; k++) begin
            prev = audio; tick();
            if (audio != prev) toggles++;
            checks++; if (audio !== m_aud) begin failures++; $display("FAIL oct2_audio cyc=%0d got=%b exp=%b", k, audio, m_aud); end
        end
        checks++; if (toggles != 10) begin failures++; $display("FAIL oct2_toggles got=%0d exp=10", toggles); end
        octave = 2'd3;
        repeat (4) tick();
        toggles = 0;
        for (int k = 0; k < 20; k++) begin
            prev = audio; tick();
            if (audio != prev) toggles++;
        end
        checks++; if (toggles != 20) begin failures++; $display("FAIL oct3_toggles got=%0d exp=20", toggles); end
        $display("test_octave done checks=%0d failures=%0d", checks, failures);
    endtask

    // Waits (bounded) for a rising audio edge; returns 1 on success.
    task automatic wait_rise(output bit found);
        bit prev;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            prev = audio; tick();
            if (!prev && audio) found = 1'b1;
        end
    endtask

    task automatic test_release();
        bit found, ea, eau;
        do_reset();
        btn = 7'b0000001;
        wait_rise(found);                       // now just after edge T
        checks++; if (!found) begin failures++; $display("FAIL rel_wait got=timeout exp=rise"); end
        repeat (18) tick();
        btn = '0;                               // first sampled at T+19
        for (int k = 19; k <= 50; k++) begin
            tick();
            ea  = (k < 24);
            eau = (k >= 20) && (k < 30);
            checks++; if (active !== ea) begin failures++; $display("FAIL rel_active T+%0d got=%b exp=%b", k, active, ea); end
            checks++; if (audio !== eau) begin failures++; $display("FAIL rel_audio T+%0d got=%b exp=%b", k, audio, eau); end
        end
        $display("test_release done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid();
        bit found, ea, eau;
        do_reset();
        btn = 7'b0000001;
        wait_rise(found);
        checks++; if (!found) begin failures++; $display("FAIL rmid_wait got=timeout exp=rise"); end
        repeat (2) tick();                      // cnt = 7, audio = 1
        checks++; if (audio !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b exp=1", audio); end
        rst = 1'b1; model_clear();
        #1;
        checks++; if (audio !== 1'b0) begin failures++; $display("FAIL rmid_async got=%b exp=0", audio); end
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k <= 20; k++) begin    // edge E+k after release
            tick();
            ea  = (k >= 5);
            eau = (k >= 6) && (k < 16);
            checks++; if (active !== ea) begin failures++; $display("FAIL rmid_active E+%0d got=%b exp=%b", k, active, ea); end
            checks++; if (audio !== eau) begin failures++; $display("FAIL rmid_audio E+%0d got=%b exp=%b", k, audio, eau); end
        end
        $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       btn = '0;
                    1:       btn = NK'(1 << $urandom_range(0, NK - 1));
                    default: btn = NK'($urandom);
                endcase
            end
            if ($urandom_range(0, 63) == 0) octave = 2'($urandom);
            tick();
            checks++; if (audio !== m_aud) begin failures++; $display("FAIL rand_audio cyc=%0d got=%b exp=%b", k, audio, m_aud); end
            checks++; if (active !== exp_active()) begin failures++; $display("FAIL rand_active cyc=%0d got=%b exp=%b", k, active, exp_active()); end
            checks++; if (note !== 3'(exp_note())) begin failures++; $display("FAIL rand_note cyc=%0d got=%0d exp=%0d", k, note, exp_note()); end
        end
        $display("test_random done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_debounce();
        test_priority();
        test_octave();
        test_release();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
